// File: rtl/topk_pkg.sv
// Shared defaults, the default-width rank entry, and the ordering function used by every compare cell.
// Defining TOPK_SIGNED_EN switches the ordering to two's-complement; otherwise it is unsigned.
package topk_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_K      = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int CMP_MAX_W  = 64;

`ifdef TOPK_SIGNED_EN
  localparam logic CMP_SIGNED = 1'b1;
`else
  localparam logic CMP_SIGNED = 1'b0;
`endif

  typedef struct packed {
    logic [DEF_DATA_W-1:0] val;
    logic [DEF_CNT_W-1:0]  cnt;
    logic                  vld;
  } topk_entry_t;

  // Flipping the sign bit of zero-extended operands turns an unsigned compare into a signed one.
  function automatic logic topk_gt(input logic [CMP_MAX_W-1:0] a,
                                   input logic [CMP_MAX_W-1:0] b,
                                   input logic [CMP_MAX_W-1:0] sign_mask);
    logic [CMP_MAX_W-1:0] flip;
    flip = CMP_SIGNED ? sign_mask : {CMP_MAX_W{1'b0}};
    return ((a ^ flip) > (b ^ flip));
  endfunction

endpackage

// File: rtl/topk_cmp_cell.sv
// One rank's comparator: flags an exact hit and whether the incoming sample may be inserted here.
// Ordering follows topk_pkg::topk_gt, so it tracks the TOPK_SIGNED_EN build option.
module topk_cmp_cell
  import topk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_val,
  input  logic              i_vld,
  output logic              o_eq,
  output logic              o_gt_or_empty
);

  localparam logic [CMP_MAX_W-1:0] SIGN_MASK = {{(CMP_MAX_W-1){1'b0}}, 1'b1} << (DATA_W-1);

  logic [CMP_MAX_W-1:0] w_a;
  logic [CMP_MAX_W-1:0] w_b;

  assign w_a           = CMP_MAX_W'(i_data);
  assign w_b           = CMP_MAX_W'(i_val);
  assign o_eq          = i_vld && (i_data == i_val);
  assign o_gt_or_empty = !i_vld || topk_gt(w_a, w_b, SIGN_MASK);

endmodule

// File: rtl/topk_tracker.sv
// Streaming tracker of the K largest distinct samples with per-rank counts and a registered rank read port.
// Build option TOPK_SIGNED_EN selects signed ordering (see topk_pkg); ports and timing are unchanged.
module topk_tracker
  import topk_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int K      = DEF_K,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int IDX_W  = $clog2(K)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_val,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic              rd_vld,
  output logic              evict,
  output logic              cnt_sat
);

  typedef struct packed {
    logic [DATA_W-1:0] val;
    logic [CNT_W-1:0]  cnt;
    logic              vld;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_W'(1);

  entry_t           r_tab [K];
  entry_t           w_nxt [K];
  entry_t           w_rd;
  logic [IDX_W-1:0] r_idx;
  logic [K-1:0]     w_eq;
  logic [K-1:0]     w_gt;
  logic [IDX_W-1:0] w_ins_idx;
  logic             w_hit;
  logic             w_ins_ok;
  logic             w_do_hit;
  logic             w_do_ins;
  logic             w_evict;
  logic             w_sat;

  genvar g;
  generate
    for (g = 0; g < K; g++) begin : g_cell
      topk_cmp_cell #(.DATA_W(DATA_W)) u_cell (
        .i_data        (in_data),
        .i_val         (r_tab[g].val),
        .i_vld         (r_tab[g].vld),
        .o_eq          (w_eq[g]),
        .o_gt_or_empty (w_gt[g])
      );
    end
  endgenerate

  // Priority encoder: lowest rank that is empty or smaller than the sample.
  always_comb begin
    w_ins_idx = '0;
    for (int i = K - 1; i >= 0; i--) begin
      w_ins_idx = w_gt[i] ? IDX_W'(i) : w_ins_idx;
    end
  end

  // A hit always wins over insertion; neither means the sample is dropped.
  assign w_hit    = |w_eq;
  assign w_ins_ok = |w_gt;
  assign w_do_hit = in_valid && w_hit;
  assign w_do_ins = in_valid && !w_hit && w_ins_ok;
  assign w_evict  = w_do_ins && r_tab[K-1].vld;

  // Next-state table: saturating count on hit, or shift-down-and-insert at the encoded rank.
  always_comb begin
    w_sat = 1'b0;
    for (int j = 0; j < K; j++) begin
      w_nxt[j] = r_tab[j];
      if (w_do_hit && w_eq[j]) begin
        w_nxt[j].cnt = (r_tab[j].cnt == CNT_MAX) ? CNT_MAX : (r_tab[j].cnt + CNT_W'(1));
        w_sat        = w_sat | (r_tab[j].cnt >= CNT_NEAR);
      end else if (w_do_ins && (IDX_W'(j) == w_ins_idx)) begin
        w_nxt[j].val = in_data;
        w_nxt[j].cnt = CNT_W'(1);
        w_nxt[j].vld = 1'b1;
      end else if (w_do_ins && (IDX_W'(j) > w_ins_idx)) begin
        w_nxt[j] = r_tab[(j > 0) ? (j - 1) : 0];
      end else begin
        w_nxt[j] = r_tab[j];
      end
    end
  end

  // Read mux; an index with no matching rank reads as an empty entry.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < K; i++) begin
      w_rd = (r_idx == IDX_W'(i)) ? r_tab[i] : w_rd;
    end
  end

  // Table, read port and flags; rst and clr both return everything to empty.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < K; i++) begin
        r_tab[i] <= '0;
      end
      r_idx   <= '0;
      rd_val  <= '0;
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      evict   <= 1'b0;
      cnt_sat <= 1'b0;
    end else begin
      r_tab   <= w_nxt;
      r_idx   <= rd_idx;
      rd_val  <= w_rd.val;
      rd_cnt  <= w_rd.cnt;
      rd_vld  <= w_rd.vld;
      evict   <= w_evict;
      cnt_sat <= cnt_sat | w_sat;
    end
  end

endmodule

// File: tb/tb_topk_tracker.sv
// Directed bench for topk_tracker: a default instance plus a CNT_W=2 instance sharing one stimulus stream.
// Expected orderings follow TOPK_SIGNED_EN when the bench is built with it.
module tb_topk_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic [1:0] rd_idx;

  logic [7:0] rd_val;
  logic [7:0] rd_cnt;
  logic       rd_vld;
  logic       evict;
  logic       cnt_sat;

  logic [7:0] s_rd_val;
  logic [1:0] s_rd_cnt;
  logic       s_rd_vld;
  logic       s_evict;
  logic       s_cnt_sat;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] exp_ord [4];

  always #5 clk = ~clk;

  topk_tracker u_dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .rd_idx(rd_idx), .rd_val(rd_val), .rd_cnt(rd_cnt), .rd_vld(rd_vld),
    .evict(evict), .cnt_sat(cnt_sat)
  );

  topk_tracker #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data),
    .rd_idx(rd_idx), .rd_val(s_rd_val), .rd_cnt(s_rd_cnt), .rd_vld(s_rd_vld),
    .evict(s_evict), .cnt_sat(s_cnt_sat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic rd_rank(input logic [1:0] idx);
    rd_idx = idx;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_rank(input string tag, input logic [1:0] idx, input logic [7:0] v,
                            input logic [7:0] c, input logic vl);
    rd_rank(idx);
    check_eq({tag, ".val"}, 32'(rd_val), 32'(v));
    check_eq({tag, ".cnt"}, 32'(rd_cnt), 32'(c));
    check_eq({tag, ".vld"}, 32'(rd_vld), 32'(vl));
  endtask

  initial begin
`ifdef TOPK_SIGNED_EN
    exp_ord[0] = 8'h01; exp_ord[1] = 8'h00; exp_ord[2] = 8'hFF; exp_ord[3] = 8'h80;
`else
    exp_ord[0] = 8'hFF; exp_ord[1] = 8'h80; exp_ord[2] = 8'h01; exp_ord[3] = 8'h00;
`endif
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'd0; rd_idx = 2'd0;
    step(); step();
    rst = 1'b0;
    check_eq("reset.rd_val", 32'(rd_val), 32'd0);
    check_eq("reset.rd_cnt", 32'(rd_cnt), 32'd0);
    check_eq("reset.rd_vld", 32'(rd_vld), 32'd0);
    check_eq("reset.evict", 32'(evict), 32'd0);
    check_eq("reset.cnt_sat", 32'(cnt_sat), 32'd0);

    // Basic ranking with a repeated value.
    send(8'd5); send(8'd9); send(8'd9); send(8'd3); send(8'd7);
    check_eq("fill.evict", 32'(evict), 32'd0);
    check_rank("fill.r0", 2'd0, 8'd9, 8'd2, 1'b1);
    check_rank("fill.r1", 2'd1, 8'd7, 8'd1, 1'b1);
    check_rank("fill.r2", 2'd2, 8'd5, 8'd1, 1'b1);
    check_rank("fill.r3", 2'd3, 8'd3, 8'd1, 1'b1);

    // Insertion into a full table evicts the old bottom entry for one cycle.
    send(8'd8);
    check_eq("ins8.evict", 32'(evict), 32'd1);
    check_eq("ins8.s_evict", 32'(s_evict), 32'd1);
    step();
    check_eq("ins8.evict_drop", 32'(evict), 32'd0);
    check_rank("ins8.r0", 2'd0, 8'd9, 8'd2, 1'b1);
    check_rank("ins8.r1", 2'd1, 8'd8, 8'd1, 1'b1);
    check_rank("ins8.r2", 2'd2, 8'd7, 8'd1, 1'b1);
    check_rank("ins8.r3", 2'd3, 8'd5, 8'd1, 1'b1);
    send(8'd1);
    check_eq("drop.evict", 32'(evict), 32'd0);
    check_rank("drop.r3", 2'd3, 8'd5, 8'd1, 1'b1);

    // Clear wins over a simultaneous sample.
    clr = 1'b1; in_valid = 1'b1; in_data = 8'd200;
    step();
    clr = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_rank("clr.rank", 2'(i), 8'd0, 8'd0, 1'b0);
    end

    // Counter saturation on the 2-bit instance.
    send(8'd6); send(8'd6);
    check_eq("sat.early", 32'(s_cnt_sat), 32'd0);
    send(8'd6); send(8'd6); send(8'd6);
    check_eq("sat.flag", 32'(s_cnt_sat), 32'd1);
    check_eq("sat.wide_flag", 32'(cnt_sat), 32'd0);
    rd_rank(2'd0);
    check_eq("sat.s_val", 32'(s_rd_val), 32'd6);
    check_eq("sat.s_cnt", 32'(s_rd_cnt), 32'd3);
    check_eq("sat.s_vld", 32'(s_rd_vld), 32'd1);
    check_eq("sat.wide_cnt", 32'(rd_cnt), 32'd5);
    send(8'd2);
    check_eq("sat.sticky", 32'(s_cnt_sat), 32'd1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    check_eq("sat.cleared", 32'(s_cnt_sat), 32'd0);

    // Ordering of sign-bit values, with zero tracked as a real value.
    send(8'hFF); send(8'h01); send(8'h80); send(8'h00);
    for (int i = 0; i < 4; i++) begin
      check_rank("order.rank", 2'(i), exp_ord[i], 8'd1, 1'b1);
    end

    // Mid-stream reset with a sample present.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'd50;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("rst.rd_val", 32'(rd_val), 32'd0);
    check_eq("rst.rd_cnt", 32'(rd_cnt), 32'd0);
    check_eq("rst.rd_vld", 32'(rd_vld), 32'd0);
    check_eq("rst.evict", 32'(evict), 32'd0);
    check_eq("rst.cnt_sat", 32'(cnt_sat), 32'd0);
    check_rank("rst.r0_empty", 2'd0, 8'd0, 8'd0, 1'b0);
    send(8'd42);
    check_rank("rst.r0", 2'd0, 8'd42, 8'd1, 1'b1);
    check_rank("rst.r1", 2'd1, 8'd0, 8'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
